aes128_round_ctrl: RTL and testbench
====================================

// Module: aes128_round_ctrl
// PURPOSE
//  Sequencer for the iterative AES-128 encrypt datapath. It drives the single shared byte-wide S-box
//  (sub_bytes). That S-box is time-shared between state SubBytes (16 bytes) and key-expansion SubWord
//  (4 bytes). The block also emits the per-round key-step, round-step, rcon and final-round bypass strobes.
//  It sits between the top-level command interface (start/ack) and the state/key register file.
// PARAMETERS
//  NR        10  number of rounds; legal 1..10
//  SBOX_LAT  0   S-box pipeline latency in clk cycles; legal 0..2
// PORTS
//  clk         in   1  clock, all logic on rising edge
//  rst         in   1  synchronous reset, active-high
//  start       in   1  begin one block encryption; sampled in IDLE only (and in DONE together with ack)
//  ack         in   1  consumer accepted result; sampled in DONE only
//  busy        out  1  1 in any state other than IDLE/DONE
//  done        out  1  result valid; held until ack
//  round       out  4  current round 1..NR; 0 in IDLE/INIT
//  init_ark    out  1  1-cycle strobe: initial AddRoundKey (state ^= key)
//  sbox_req    out  1  S-box input byte valid this cycle
//  sbox_src    out  1  0 = state byte, 1 = key byte feeds S-box
//  sbox_idx    out  4  byte index read into S-box
//  sbox_we     out  1  write S-box result back (sbox_req delayed SBOX_LAT)
//  wb_src      out  1  destination: 0 = state byte, 1 = temp key word
//  wb_idx      out  4  destination byte index (sbox_idx mapped, delayed SBOX_LAT)
//  key_step    out  1  1-cycle strobe: expand round key using temp word ^ rcon
//  rcon        out  8  round constant, valid whenever round != 0
//  round_step  out  1  1-cycle strobe: ShiftRows, MixColumns, AddRoundKey
//  mix_bypass  out  1  with round_step: skip MixColumns (round == NR)
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including rcon and round.
//  FSM: IDLE -> INIT -> {KSUB -> KXOR -> SSUB -> RND} x NR -> DONE.
//  IDLE: start=1 -> INIT. Otherwise stay.
//  INIT: 1 cycle. init_ark=1. Next-state round<=1, rcon<=8'h01.
//  KSUB: 4+SBOX_LAT cycles. First 4 cycles: sbox_req=1, src=1, sbox_idx = 13,14,15,12 (RotWord of w3).
//   Writeback cycles: wb_src=1, wb_idx = 0,1,2,3.
//  KXOR: 1 cycle, key_step=1.
//  SSUB: 16+SBOX_LAT cycles. First 16 cycles: sbox_req=1, src=0, sbox_idx = 0..15.
//   Writeback: wb_src=0, wb_idx = 0..15.
//  RND: 1 cycle. round_step=1, mix_bypass=(round==NR).
//   If round==NR -> DONE. Else round+1, rcon<=xtime(rcon) (poly 8'h1B), then KSUB.
//  rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
//  DONE: done=1, busy=0.
//   ack=0: stay.
//   ack=1,start=0: -> IDLE.
//   ack=1,start=1: -> INIT directly; no idle cycle.
//  start outside IDLE/DONE ignored; ack outside DONE ignored.
//  Latency: edge sampling start -> done high after 1 + NR*(22 + 2*SBOX_LAT) edges. NR=10, L=0: 221.
//  sbox_we/wb_* are sbox_req/src/idx passed through an SBOX_LAT-deep shift register.
//   Phase does not advance until its last writeback is issued; no read/write overlap across phases.
//  rst mid-operation: next edge -> IDLE, all outputs 0, writeback pipe flushed (no stray sbox_we).
//  Counters: byte counter 4 bits, wraps never used (phase exits on terminal count); round counter 4 bits.
// STRUCTURE
//  Shared package aes128_pkg:
//   state enum {IDLE, INIT, KSUB, KXOR, SSUB, RND, DONE}
//   RCON_INIT=8'h01, AES_POLY=8'h1B, NB_BYTES=16, KW_BYTES=4, key RotWord index table {13,14,15,12}.
//  One sub-module: aes128_rcon_gen (rcon register; load 01 on INIT, xtime on advance, clear on rst).
//  FSM, byte counter and SBOX_LAT writeback delay line stay in this module.
// TESTING
//  1 rst=1 two cycles -> all outputs 0, round=0, busy=0, done=0; no strobes while idle.
//  2 NR=10,L=0, start pulse -> done after exactly 221 edges.
//    10 key_step, 10 round_step, one init_ark; mix_bypass only on 10th round_step.
//    rcon at each key_step = 01,02,04,08,10,20,40,80,1B,36.
//  3 Round 1 trace -> src=1, idx 13,14,15,12 (wb_idx 0..3); key_step; src=0, idx 0..15; round_step.
//  4 start held high during busy -> ignored, single op.
//    In DONE, ack=1 & start=1 -> INIT next cycle, second done 221 edges later.
//    ack=0 for 5 cycles -> done stays 1.
//  5 rst asserted during SSUB of round 5 -> next cycle IDLE, no sbox_we afterwards.
//    New start -> full 221-edge run, rcon restarts at 01.
//  6 SBOX_LAT=2 -> sbox_we/wb_idx lag sbox_req/idx by 2 cycles; total latency 1+10*26 = 261.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared constants, types and helpers for the iterative AES-128 encrypt sequencer.
package aes128_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KSUB, ST_KXOR, ST_SSUB, ST_RND, ST_DONE
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] AES_POLY  = 8'h1B;
  localparam int         NB_BYTES  = 16;
  localparam int         KW_BYTES  = 4;

  // S-box read order for SubWord(RotWord(w3)): bytes 13,14,15,12 of the key
  localparam logic [3:0] KEY_ROT_IDX [KW_BYTES] = '{4'd13, 4'd14, 4'd15, 4'd12};

  // One S-box operation as it travels through the writeback delay line
  typedef struct packed {
    logic       vld;
    logic       src;
    logic [3:0] widx;
    logic       last;
  } sbox_op_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_round_ctrl_if.sv
// Command handshake plus datapath strobes between the sequencer and its neighbours.
interface aes128_round_ctrl_if;
  logic       start;
  logic       ack;
  logic       busy;
  logic       done;
  logic [3:0] round;
  logic       init_ark;
  logic       sbox_req;
  logic       sbox_src;
  logic [3:0] sbox_idx;
  logic       sbox_we;
  logic       wb_src;
  logic [3:0] wb_idx;
  logic       key_step;
  logic [7:0] rcon;
  logic       round_step;
  logic       mix_bypass;

  // master issues commands and consumes strobes; slave is the sequencer
  modport master (
    output start, ack,
    input  busy, done, round, init_ark, sbox_req, sbox_src, sbox_idx,
           sbox_we, wb_src, wb_idx, key_step, rcon, round_step, mix_bypass
  );
  modport slave (
    input  start, ack,
    output busy, done, round, init_ark, sbox_req, sbox_src, sbox_idx,
           sbox_we, wb_src, wb_idx, key_step, rcon, round_step, mix_bypass
  );
endinterface

// File: rtl/aes128_rcon_gen.sv
// Round-constant register: loads 01 at block start, doubles in GF(2^8) per round.
module aes128_rcon_gen
  import aes128_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_adv,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk) begin
    if (rst)         r_rcon <= 8'h00;
    else if (i_load) r_rcon <= RCON_INIT;
    else if (i_adv)  r_rcon <= xtime(r_rcon);
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: time-shares one S-box between
// key SubWord and state SubBytes and emits the per-round step strobes.
module aes128_round_ctrl
  import aes128_pkg::*;
#(
  parameter int NR       = 10,
  parameter int SBOX_LAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  aes128_round_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_INIT = ST_INIT;
  localparam logic [2:0] S_KSUB = ST_KSUB;
  localparam logic [2:0] S_KXOR = ST_KXOR;
  localparam logic [2:0] S_SSUB = ST_SSUB;
  localparam logic [2:0] S_RND  = ST_RND;
  localparam logic [2:0] S_DONE = ST_DONE;

  logic [2:0] r_state, w_next;
  logic [3:0] r_cnt;
  logic [3:0] r_round;
  logic       r_rd_done;
  logic       w_ksub, w_ssub, w_last_round;
  logic [3:0] w_sidx;
  logic [7:0] w_rcon;
  sbox_op_t   w_rd, w_wb;

  assign w_ksub       = (r_state == S_KSUB);
  assign w_ssub       = (r_state == S_SSUB);
  assign w_last_round = (r_round == 4'(NR));

  // Issue side: reads stop once the phase's last byte has gone in, then the
  // phase idles until that byte's writeback emerges from the delay line.
  always_comb begin
    w_rd   = '0;
    w_sidx = 4'd0;
    if ((w_ksub || w_ssub) && !r_rd_done) begin
      w_rd.vld  = 1'b1;
      w_rd.src  = w_ksub;
      w_rd.widx = r_cnt;
      w_rd.last = (r_cnt == (w_ksub ? 4'(KW_BYTES - 1) : 4'(NB_BYTES - 1)));
      w_sidx    = w_ksub ? KEY_ROT_IDX[r_cnt[1:0]] : r_cnt;
    end
  end

  generate
    if (SBOX_LAT == 0) begin : g_nodly
      assign w_wb = w_rd;
    end else begin : g_dly
      sbox_op_t r_dly [SBOX_LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SBOX_LAT; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_rd;
          for (int i = 1; i < SBOX_LAT; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_wb = r_dly[SBOX_LAT-1];
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_INIT;
      S_INIT: w_next = S_KSUB;
      S_KSUB: if (w_wb.vld && w_wb.last) w_next = S_KXOR;
      S_KXOR: w_next = S_SSUB;
      S_SSUB: if (w_wb.vld && w_wb.last) w_next = S_RND;
      S_RND:  w_next = w_last_round ? S_DONE : S_KSUB;
      S_DONE: if (bus.ack) w_next = bus.start ? S_INIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_rd_done <= 1'b0;
      r_round   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_rd.vld) r_cnt <= w_rd.last ? 4'd0 : r_cnt + 4'd1;
      // phase exit wins over the last-read flag so the next phase starts clean
      if (w_next != r_state)          r_rd_done <= 1'b0;
      else if (w_rd.vld && w_rd.last) r_rd_done <= 1'b1;
      if (r_state == S_INIT)                      r_round <= 4'd1;
      else if (r_state == S_RND && !w_last_round) r_round <= r_round + 4'd1;
      else if (r_state == S_DONE && bus.ack)      r_round <= 4'd0;
    end
  end

  aes128_rcon_gen u_rcon (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == S_INIT),
    .i_adv  (r_state == S_RND && !w_last_round),
    .o_rcon (w_rcon)
  );

  assign bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.round      = r_round;
  assign bus.init_ark   = (r_state == S_INIT);
  assign bus.sbox_req   = w_rd.vld;
  assign bus.sbox_src   = w_rd.src;
  assign bus.sbox_idx   = w_sidx;
  assign bus.sbox_we    = w_wb.vld;
  assign bus.wb_src     = w_wb.src;
  assign bus.wb_idx     = w_wb.widx;
  assign bus.key_step   = (r_state == S_KXOR);
  assign bus.rcon       = (r_round != 4'd0) ? w_rcon : 8'h00;
  assign bus.round_step = (r_state == S_RND);
  assign bus.mix_bypass = (r_state == S_RND) && w_last_round;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench: per-cycle trace model built from the round schedule, two DUTs (latency 0 and 2).
module tb_aes128_round_ctrl;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes128_round_ctrl_if if0 ();
  aes128_round_ctrl_if if2 ();

  aes128_round_ctrl #(.NR(NR), .SBOX_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  aes128_round_ctrl #(.NR(NR), .SBOX_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  typedef struct packed {
    logic       busy, done;
    logic [3:0] round;
    logic       init_ark, req, src;
    logic [3:0] idx;
    logic       we, wsrc;
    logic [3:0] widx;
    logic       key_step;
    logic [7:0] rcon;
    logic       rstep, mixb;
  } rec_t;

  int   checks   = 0;
  int   failures = 0;
  rec_t exp_q[$];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [3:0] key_order [4] = '{4'd13, 4'd14, 4'd15, 4'd12};

  // Observed outputs with don't-care fields (idx/src when not valid, rcon at round 0) zeroed
  function automatic rec_t obs(input int sel);
    rec_t o;
    o = '0;
    if (sel == 0) begin
      o = '{if0.busy, if0.done, if0.round, if0.init_ark, if0.sbox_req, if0.sbox_src, if0.sbox_idx,
            if0.sbox_we, if0.wb_src, if0.wb_idx, if0.key_step, if0.rcon, if0.round_step, if0.mix_bypass};
    end else begin
      o = '{if2.busy, if2.done, if2.round, if2.init_ark, if2.sbox_req, if2.sbox_src, if2.sbox_idx,
            if2.sbox_we, if2.wb_src, if2.wb_idx, if2.key_step, if2.rcon, if2.round_step, if2.mix_bypass};
    end
    if (!o.req) begin o.src = 1'b0; o.idx = 4'd0; end
    if (!o.we)  begin o.wsrc = 1'b0; o.widx = 4'd0; end
    if (o.round == 4'd0) o.rcon = 8'h00;
    return o;
  endfunction

  task automatic drive(input int sel, input logic s, input logic a);
    if (sel == 0) begin if0.start = s; if0.ack = a; end
    else          begin if2.start = s; if2.ack = a; end
  endtask

  // Expected per-cycle outputs from the INIT cycle up to (not including) DONE
  task automatic build_trace(input int lat);
    rec_t e;
    exp_q.delete();
    e = '0; e.busy = 1'b1; e.init_ark = 1'b1;
    exp_q.push_back(e);
    for (int r = 1; r <= NR; r++) begin
      for (int c = 0; c < 4 + lat; c++) begin
        e = '0; e.busy = 1'b1; e.round = 4'(r); e.rcon = rcon_tab[r-1];
        if (c < 4)    begin e.req = 1'b1; e.src = 1'b1; e.idx = key_order[c]; end
        if (c >= lat) begin e.we = 1'b1; e.wsrc = 1'b1; e.widx = 4'(c - lat); end
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.round = 4'(r); e.rcon = rcon_tab[r-1]; e.key_step = 1'b1;
      exp_q.push_back(e);
      for (int c = 0; c < 16 + lat; c++) begin
        e = '0; e.busy = 1'b1; e.round = 4'(r); e.rcon = rcon_tab[r-1];
        if (c < 16)   begin e.req = 1'b1; e.idx = 4'(c); end
        if (c >= lat) begin e.we = 1'b1; e.widx = 4'(c - lat); end
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.round = 4'(r); e.rcon = rcon_tab[r-1];
      e.rstep = 1'b1; e.mixb = (r == NR);
      exp_q.push_back(e);
    end
  endtask

  // Called #1 after the edge that sampled start; leaves #1 after the first DONE edge.
  task automatic run_trace(input int sel, input string name,
                           output int n_ks, output int n_rs, output int n_ia,
                           output int n_mb, output int mb_ord);
    rec_t o;
    n_ks = 0; n_rs = 0; n_ia = 0; n_mb = 0; mb_ord = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      o = obs(sel);
      checks++;
      if (o !== exp_q[k]) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, o, exp_q[k]);
      end
      if (o.key_step) n_ks++;
      if (o.rstep)    n_rs++;
      if (o.init_ark) n_ia++;
      if (o.mixb) begin n_mb++; mb_ord = n_rs; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    o = obs(sel);
    checks++;
    if (!(o.done === 1'b1 && o.busy === 1'b0)) begin
      failures++;
      $display("FAIL %s_latency done=%b busy=%b exp done=1 busy=0 after %0d edges",
               name, o.done, o.busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic kick(input int sel, input logic hold);
    drive(sel, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(sel, hold, 1'b0);
  endtask

  task automatic check_counts(input string name, input int n_ks, input int n_rs,
                              input int n_ia, input int n_mb, input int mb_ord);
    checks++;
    if (n_ks != NR || n_rs != NR || n_ia != 1 || n_mb != 1 || mb_ord != NR) begin
      failures++;
      $display("FAIL %s_strobes ks=%0d rs=%0d ia=%0d mb=%0d mb_at=%0d exp %0d/%0d/1/1/%0d",
               name, n_ks, n_rs, n_ia, n_mb, mb_ord, NR, NR, NR);
    end
  endtask

  task automatic ack_to_idle(input int sel, input string name);
    rec_t o;
    drive(sel, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0);
    o = obs(sel);
    checks++;
    if (o.busy !== 1'b0 || o.done !== 1'b0 || o.round !== 4'd0) begin
      failures++;
      $display("FAIL %s_ack_idle busy=%b done=%b round=%0d exp 0/0/0", name, o.busy, o.done, o.round);
    end
  endtask

  task automatic test_reset();
    rec_t o;
    drive(0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s <= 2; s += 2) begin
      o = obs(s);
      checks++;
      if (o !== '0 || (s == 0 ? if0.rcon : if2.rcon) !== 8'h00) begin
        failures++;
        $display("FAIL reset_state dut=%0d got=%h exp=0", s, o);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(0, 1'b0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      o = obs(0);
      checks++;
      if (o !== '0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got=%h exp=0", c, o);
      end
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0);
  endtask

  task automatic test_full_run();
    int ks, rs, ia, mb, mo;
    build_trace(0);
    kick(0, 1'b0);
    run_trace(0, "full_run", ks, rs, ia, mb, mo);
    check_counts("full_run", ks, rs, ia, mb, mo);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (if0.done !== 1'b1) begin
        failures++;
        $display("FAIL done_hold cyc=%0d done=%b exp=1", c, if0.done);
      end
      @(posedge clk); #1;
    end
    ack_to_idle(0, "full_run");
  endtask

  task automatic test_back_to_back();
    int ks, rs, ia, mb, mo;
    build_trace(0);
    kick(0, 1'b1);
    run_trace(0, "start_held", ks, rs, ia, mb, mo);
    check_counts("start_held", ks, rs, ia, mb, mo);
    drive(0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0);
    run_trace(0, "b2b", ks, rs, ia, mb, mo);
    check_counts("b2b", ks, rs, ia, mb, mo);
    ack_to_idle(0, "b2b");
  endtask

  task automatic test_reset_mid();
    int   ks, rs, ia, mb, mo, k;
    rec_t o;
    build_trace(0);
    k = 94 + int'($urandom_range(0, 15));
    kick(0, 1'b0);
    repeat (k) @(posedge clk);
    #1;
    @(negedge clk);
    o = obs(0);
    checks++;
    if (o !== exp_q[k]) begin
      failures++;
      $display("FAIL mid_position cyc=%0d got=%h exp=%h", k, o, exp_q[k]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    o = obs(0);
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0", o);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (if0.sbox_we !== 1'b0 || if0.busy !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet cyc=%0d we=%b busy=%b exp 0/0", c, if0.sbox_we, if0.busy);
      end
      @(posedge clk); #1;
    end
    kick(0, 1'b0);
    run_trace(0, "rerun", ks, rs, ia, mb, mo);
    check_counts("rerun", ks, rs, ia, mb, mo);
    ack_to_idle(0, "rerun");
  endtask

  task automatic test_lat2();
    int ks, rs, ia, mb, mo;
    build_trace(2);
    kick(2, 1'b0);
    run_trace(2, "lat2", ks, rs, ia, mb, mo);
    check_counts("lat2", ks, rs, ia, mb, mo);
    ack_to_idle(2, "lat2");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_back_to_back();
    test_reset_mid();
    test_lat2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
